cam_line_buffer: RTL and testbench
==================================

CAM_LINE_BUFFER -- requirements
Module: cam_line_buffer

Interface
REQ-001 Parameter PIX_W, default 6, camera pixel width in bits.
REQ-002 Parameter LINE_LEN, default 320, maximum stored pixels per line.
REQ-003 Parameter NUM_BUFS, default 2 (range 2-4), number of line banks in the ring.
REQ-004 pclk  input  1  camera pixel clock; the single clock for all logic.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 camD  input  PIX_W  pixel data, sampled when camValid=1.
REQ-007 camValid  input  1  pixel qualifier.
REQ-008 hBlank  input  1  one-cycle end-of-line strobe.
REQ-009 vBlank  input  1  one-cycle start-of-frame strobe.
REQ-010 decim  input  1  0 = keep all pixels; 1 = keep even pixels of even lines only.
REQ-011 rdReq  input  1  read one pixel from the oldest committed bank.
REQ-012 rdData  output  PIX_W  read pixel.
REQ-013 rdValid  output  1  rdData qualifier.
REQ-014 rdLast  output  1  with rdValid, marks the final pixel of the line.
REQ-015 lineReady  output  1  at least one committed bank is unread.
REQ-016 overflow  output  1  sticky flag: a line was dropped because no bank was free.
REQ-017 lineCount  output  10  lines committed since the last vBlank, saturating at 1023.

Function
REQ-018 Write side: an accepted pixel is written at wAddr of bank wBank, then wAddr increments.
- Accepted pixel: camValid=1; decim rule passes; wAddr<LINE_LEN; line not dropping.
REQ-019 Decimation counters:
- pixIdx counts camValid pixels in the line; lineIdx counts hBlank strobes in the frame.
- hBlank clears pixIdx; vBlank clears both.
- decim=1 accepts only when pixIdx[0]=0 and lineIdx[0]=0.
REQ-020 Pixels arriving at wAddr=LINE_LEN are discarded silently.
REQ-021 Drop decision: at the first accepted pixel of a line, if bank wBank is full, the line is marked dropping.
- No writes occur for the rest of that line.
- overflow is set on the following cycle.
REQ-022 Commit on hBlank when wAddr>0 and the line is not dropping:
- bank wBank marked full with length wAddr;
- wBank advances modulo NUM_BUFS;
- lineCount increments;
- wAddr clears.
REQ-023 hBlank with wAddr=0, or on a dropping line: clear wAddr and the dropping flag; wBank is not advanced.
REQ-024 camValid and hBlank in the same cycle: the pixel is written first and included in the committed line.
REQ-025 vBlank:
- the partial line is discarded (wAddr clears, dropping clears);
- lineCount and overflow clear;
- committed banks and read state are retained.
REQ-026 vBlank wins over a simultaneous hBlank; no commit occurs.
REQ-027 lineReady is registered; it is 1 while any bank is full and rises the cycle after a commit.
REQ-028 Read side: rdReq while lineReady=1 reads bank rBank at rAddr.
- Read latency is exactly 1 cycle: rdValid=1 and rdData valid on the following cycle.
- rdReq while lineReady=0 is ignored; rdValid stays 0.
REQ-029 rdLast=1 with the pixel at rAddr=length-1. That read:
- clears the bank's full flag on the same edge;
- clears rAddr;
- advances rBank modulo NUM_BUFS.
REQ-030 A bank freed by a read in cycle N is available to a drop decision from cycle N+1. A drop decision in cycle N sees pre-free status.
REQ-031 A commit and a read-free of different banks in the same cycle both take effect.
REQ-032 Bank storage is PIX_W x (NUM_BUFS*LINE_LEN), inferable as block RAM, with a 1-cycle registered read port.

Reset
REQ-033 rstn=0 asynchronously clears all of the following:
- wAddr, rAddr, wBank, rBank, all full flags, the dropping flag;
- pixIdx, lineIdx, lineCount;
- overflow, rdValid, rdLast, lineReady, rdData (all 0).
REQ-034 Reset does not initialise RAM contents; stale data is unreachable because no bank is full.
REQ-035 Reset mid-line or mid-read abandons all lines; after release, the first accepted pixel goes to bank 0, address 0.

Verification
REQ-036 Basic line: decim=0, 8 pixels 1..8, then hBlank.
- Required: lineReady=1 next cycle; lineCount=1.
- 8 rdReq cycles return 1..8 one cycle later; rdLast on 8; lineReady then 0.
REQ-037 Decimation: decim=1, vBlank, two lines of pixels 0..7.
- Required: one committed line holding 0,2,4,6; lineCount=1 on a committed line.
- The second line is empty; no commit and no bank advance.
REQ-038 Overflow: NUM_BUFS=2, commit 3 lines with no reads.
- Required: line 3 dropped; overflow=1; lineCount=2.
- Reading returns lines 1 and 2 intact; vBlank clears overflow.
REQ-039 Truncation: LINE_LEN=320, 330 pixels then hBlank.
- Required: length 320; rdLast on the 320th read.
REQ-040 Simultaneous events:
- camValid+hBlank on pixel 5: the line has 5 pixels.
- hBlank+vBlank together: no commit.
- Free and first pixel in the same cycle: the line is dropped.
REQ-041 Reset mid-read of line 2 (rAddr=3): all outputs 0.
- Next line after release is read back from address 0 correctly.

Source files
------------

// File: rtl/cam_line_buffer.sv
// Camera line buffer: captures pixel lines into a ring of line banks and
// replays the oldest committed line one pixel per read request.
// Write and read sides share pclk; banks hand off through per-bank full flags.
module cam_line_buffer #(
  parameter int PIX_W    = 6,
  parameter int LINE_LEN = 320,
  parameter int NUM_BUFS = 2
) (
  input  logic             pclk,
  input  logic             rstn,
  input  logic [PIX_W-1:0] camD,
  input  logic             camValid,
  input  logic             hBlank,
  input  logic             vBlank,
  input  logic             decim,
  input  logic             rdReq,
  output logic [PIX_W-1:0] rdData,
  output logic             rdValid,
  output logic             rdLast,
  output logic             lineReady,
  output logic             overflow,
  output logic [9:0]       lineCount
);

  localparam int AW = $clog2(LINE_LEN + 1);
  localparam int BW = (NUM_BUFS > 2) ? 2 : 1;
  localparam int MW = $clog2(NUM_BUFS * LINE_LEN);
  localparam logic [AW-1:0] LEN_MAX   = AW'(LINE_LEN);
  localparam logic [MW-1:0] LEN_M     = MW'(LINE_LEN);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BUFS - 1);

  // Write-side state
  logic [AW-1:0]    r_wAddr;
  logic [BW-1:0]    r_wBank;
  logic             r_dropping;
  // Only the parity of the pixel/line counters feeds the decimation rule,
  // so each counter is kept modulo 2.
  logic             r_pixIdx;
  logic             r_lineIdx;
  logic [9:0]       r_lineCount;
  logic             r_overflow;

  // Bank bookkeeping
  logic [NUM_BUFS-1:0] r_full;
  logic [AW-1:0]       r_len [NUM_BUFS];
  logic                r_lineReady;

  // Read-side state
  logic [AW-1:0]    r_rAddr;
  logic [BW-1:0]    r_rBank;
  logic [PIX_W-1:0] r_rdData;
  logic             r_rdValid;
  logic             r_rdLast;

  // Line storage (no reset, block-RAM friendly)
  logic [PIX_W-1:0] r_mem [NUM_BUFS * LINE_LEN];

  // Combinational control
  logic                w_decimOk;
  logic                w_cand;
  logic                w_drop;
  logic                w_wr;
  logic [AW-1:0]       w_len;
  logic                w_commit;
  logic                w_rd;
  logic                w_rLast;
  logic [MW-1:0]       w_wIdx;
  logic [MW-1:0]       w_rIdx;
  logic [NUM_BUFS-1:0] w_fullNxt;

  function automatic logic [BW-1:0] f_nextBank(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  // Pixel acceptance, drop decision and commit qualification
  always_comb begin
    w_decimOk = ~decim | (~r_pixIdx & ~r_lineIdx);
    w_cand    = camValid & w_decimOk & (r_wAddr < LEN_MAX) & ~r_dropping & ~vBlank;
    // The drop test looks at the registered full flag, so a bank freed in
    // this same cycle still counts as full.
    w_drop    = w_cand & (r_wAddr == '0) & r_full[r_wBank];
    w_wr      = w_cand & ~w_drop;
    // A pixel arriving together with hBlank belongs to the committed line.
    w_len     = r_wAddr + AW'(w_wr);
    w_commit  = hBlank & ~vBlank & ~r_dropping & (w_len != '0);
    w_rd      = rdReq & r_lineReady;
    w_rLast   = w_rd & (r_rAddr == (r_len[r_rBank] - AW'(1)));
    w_wIdx    = LEN_M * MW'(r_wBank) + MW'(r_wAddr);
    w_rIdx    = LEN_M * MW'(r_rBank) + MW'(r_rAddr);
  end

  // Next full flags: commit and read-free always hit different banks
  always_comb begin
    w_fullNxt = r_full;
    if (w_rLast)  w_fullNxt[r_rBank] = 1'b0;
    if (w_commit) w_fullNxt[r_wBank] = 1'b1;
  end

  // Pixel storage write port
  always_ff @(posedge pclk) begin
    if (w_wr) r_mem[w_wIdx] <= camD;
  end

  // Write side: address, bank, framing counters, commit and overflow
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_wAddr     <= '0;
      r_wBank     <= '0;
      r_dropping  <= 1'b0;
      r_pixIdx    <= 1'b0;
      r_lineIdx   <= 1'b0;
      r_lineCount <= '0;
      r_overflow  <= 1'b0;
      for (int unsigned i = 0; i < NUM_BUFS; i++) r_len[i] <= '0;
    end else if (vBlank) begin
      r_wAddr     <= '0;
      r_dropping  <= 1'b0;
      r_pixIdx    <= 1'b0;
      r_lineIdx   <= 1'b0;
      r_lineCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (hBlank) begin
        r_pixIdx   <= 1'b0;
        r_lineIdx  <= ~r_lineIdx;
        r_wAddr    <= '0;
        r_dropping <= 1'b0;
        if (w_commit) begin
          r_len[r_wBank] <= w_len;
          r_wBank        <= f_nextBank(r_wBank);
          if (r_lineCount != '1) r_lineCount <= r_lineCount + 1'b1;
        end
      end else begin
        if (camValid) r_pixIdx <= ~r_pixIdx;
        if (w_wr)     r_wAddr  <= r_wAddr + 1'b1;
        if (w_drop)   r_dropping <= 1'b1;
      end
    end
  end

  // Read side: full flags, lineReady, read address/bank and output register
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_full      <= '0;
      r_lineReady <= 1'b0;
      r_rAddr     <= '0;
      r_rBank     <= '0;
      r_rdData    <= '0;
      r_rdValid   <= 1'b0;
      r_rdLast    <= 1'b0;
    end else begin
      r_full      <= w_fullNxt;
      r_lineReady <= |w_fullNxt;
      r_rdValid   <= w_rd;
      r_rdLast    <= w_rLast;
      if (w_rd) begin
        r_rdData <= r_mem[w_rIdx];
        if (w_rLast) begin
          r_rAddr <= '0;
          r_rBank <= f_nextBank(r_rBank);
        end else begin
          r_rAddr <= r_rAddr + 1'b1;
        end
      end
    end
  end

  assign rdData    = r_rdData;
  assign rdValid   = r_rdValid;
  assign rdLast    = r_rdLast;
  assign lineReady = r_lineReady;
  assign overflow  = r_overflow;
  assign lineCount = r_lineCount;

endmodule

// File: tb/tb_cam_line_buffer.sv
// Directed bench for cam_line_buffer (PIX_W=6, LINE_LEN=320, NUM_BUFS=2).
module tb_cam_line_buffer;

  logic       pclk = 1'b0;
  logic       rstn;
  logic [5:0] camD;
  logic       camValid, hBlank, vBlank, decim, rdReq;
  logic [5:0] rdData;
  logic       rdValid, rdLast, lineReady, overflow;
  logic [9:0] lineCount;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  cam_line_buffer #(.PIX_W(6), .LINE_LEN(320), .NUM_BUFS(2)) dut (
    .pclk(pclk), .rstn(rstn), .camD(camD), .camValid(camValid),
    .hBlank(hBlank), .vBlank(vBlank), .decim(decim), .rdReq(rdReq),
    .rdData(rdData), .rdValid(rdValid), .rdLast(rdLast),
    .lineReady(lineReady), .overflow(overflow), .lineCount(lineCount)
  );

  typedef struct {
    logic       cv;  logic [5:0] d;  logic hb; logic vb; logic dec; logic rr;
    logic       ev;  logic [5:0] ed; logic el; logic elr; logic eov; logic [9:0] elc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cv, input logic [5:0] d, input logic hb, input logic vb,
                     input logic dec, input logic rr, input logic ev, input logic [5:0] ed,
                     input logic el, input logic elr, input logic eov, input logic [9:0] elc);
    vec_t v;
    v.cv = cv; v.d = d; v.hb = hb; v.vb = vb; v.dec = dec; v.rr = rr;
    v.ev = ev; v.ed = ed; v.el = el; v.elr = elr; v.eov = eov; v.elc = elc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [5:0] d, input logic hb, input logic vb,
                       input logic dec, input logic rr);
    camValid = cv; camD = d; hBlank = hb; vBlank = vb; decim = dec; rdReq = rr;
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Basic line: 1..8, commit, read back
    for (int k = 1; k <= 8; k++) add(1, 6'(k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 1, 1, 6'(k), 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 8, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Decimation: line 0 keeps 0,2,4,6; line 1 keeps nothing
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(1, 6'(k), 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 8; k++) add(1, 6'(k + 8), 0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 6, 1, 0, 0, 1);
    // Overflow: two commits fill both banks, third line dropped
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 10; k <= 12; k++) add(1, 6'(k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 21; k <= 22; k++) add(1, 6'(k), 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    for (int k = 31; k <= 33; k++) add(1, 6'(k), 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 10, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 11, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 12, 1, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 21, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 22, 1, 0, 1, 2);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // camValid + hBlank on pixel 5
    for (int k = 1; k <= 4; k++) add(1, 6'(k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 0, 1, 1, 6'(k), 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0, 1);
    // hBlank + vBlank: partial line discarded, no commit
    add(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 41, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 40, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 41, 1, 0, 0, 1);
    // Free and first pixel in the same cycle: line dropped
    add(1, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 51, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(1, 60, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 1, 50, 0, 1, 0, 3);
    add(1, 70, 0, 0, 0, 1, 1, 51, 1, 1, 1, 3);
    add(1, 71, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    add(1, 80, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 0, 1, 1, 60, 1, 1, 1, 4);
    add(0, 0, 0, 0, 0, 1, 1, 80, 1, 0, 1, 4);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- reset ----------------
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    chk("reset_outputs", {rdData, rdValid, rdLast, lineReady, overflow, lineCount}, '0);
    rstn = 1'b1;
    step();

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cv, tbl[i].d, tbl[i].hb, tbl[i].vb, tbl[i].dec, tbl[i].rr);
      step();
      chk($sformatf("vec[%0d]", i),
          {rdValid, (rdValid ? rdData : 6'd0), rdLast, lineReady, overflow, lineCount},
          {tbl[i].ev, (tbl[i].ev ? tbl[i].ed : 6'd0), tbl[i].el, tbl[i].elr, tbl[i].eov, tbl[i].elc});
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    // ---------------- truncation: 330 pixels, 320 kept ----------------
    for (int i = 0; i < 330; i++) begin
      drive(1, 6'(i), 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 1, 0, 0, 0);
    step();
    chk("trunc_commit", {lineReady, lineCount}, {1'b1, 10'd1});
    for (int i = 0; i < 320; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      step();
      chk($sformatf("trunc_rd[%0d]", i), {rdValid, rdData, rdLast},
          {1'b1, 6'(i), (i == 319)});
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("trunc_empty", {rdValid, lineReady}, '0);

    // ---------------- reset mid-read of line 2 ----------------
    for (int k = 1; k <= 3; k++) begin drive(1, 6'(k), 0, 0, 0, 0); step(); end
    drive(0, 0, 1, 0, 0, 0); step();
    for (int k = 11; k <= 16; k++) begin drive(1, 6'(k), 0, 0, 0, 0); step(); end
    drive(0, 0, 1, 0, 0, 0); step();
    chk("mr_count", lineCount, 32'd3);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 0, 1); step();
      chk("mr_line1", {rdValid, rdData, rdLast}, {1'b1, 6'(k), (k == 3)});
    end
    for (int k = 11; k <= 13; k++) begin
      drive(0, 0, 0, 0, 0, 1); step();
      chk("mr_line2", {rdValid, rdData, rdLast}, {1'b1, 6'(k), 1'b0});
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mr_async_reset", {rdData, rdValid, rdLast, lineReady, overflow, lineCount}, '0);
    step(); step();
    rstn = 1'b1;
    step();
    for (int k = 60; k <= 63; k++) begin drive(1, 6'(k), 0, 0, 0, 0); step(); end
    drive(0, 0, 1, 0, 0, 0); step();
    chk("mr_recommit", {lineReady, lineCount}, {1'b1, 10'd1});
    for (int k = 60; k <= 63; k++) begin
      drive(0, 0, 0, 0, 0, 1); step();
      chk("mr_reread", {rdValid, rdData, rdLast, lineReady},
          {1'b1, 6'(k), (k == 63), (k != 63)});
    end
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
